// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared constants, tag type and OPMODE helper for the DSP48A1 MAC sequencer.
package dsp_mac_sequencer_pkg;

  localparam int OP_W      = 18;  // operand width
  localparam int P_W       = 48;  // slice P / result width
  localparam int LAT       = 3;   // operand issue -> P holds product
  localparam int OPM_SKEW  = 1;   // OPMODE issue lags operand issue
  localparam int RES_DEPTH = 2;   // result FIFO entries / max outstanding results
  localparam int INIT_CYC  = 2;   // slice reset cycles after RST_N release
  localparam int OUT_W     = 4;   // holds fifo count + every last in the tag pipe

  // X=M, Z=0 : start a new sum
  localparam logic [7:0] OPM_FIRST = 8'h01;
  // X=M, Z=P : accumulate
  localparam logic [7:0] OPM_ACC   = 8'h09;
  // X=0, Z=P : P holds through a bubble
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  // OPMODE the slice needs for the beat described by this tag
  function automatic logic [7:0] opm_from_tag(input tag_t t);
    logic [7:0] opm;
    if (!t.vld) begin
      opm = OPM_HOLD;
    end else if (t.first) begin
      opm = OPM_FIRST;
    end else begin
      opm = OPM_ACC;
    end
    return opm;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count.
module dsp_result_fifo
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int DEPTH = RES_DEPTH,
  parameter int W     = P_W,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [W-1:0]     o_data,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [0:DEPTH-1];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != {CNT_W{1'b0}});

  // Storage, pointers and occupancy; memory cleared so the head reads 0 after reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid = (r_count != {CNT_W{1'b0}});
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice in MAC mode: skews OPMODE against the operands,
// tracks beats through the slice latency and collects one result per vector.
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
(
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            S_VALID,
  output logic            S_READY,
  input  logic [OP_W-1:0] S_A,
  input  logic [OP_W-1:0] S_B,
  input  logic            S_LAST,
  output logic [OP_W-1:0] DSP_A,
  output logic [OP_W-1:0] DSP_B,
  output logic [7:0]      DSP_OPMODE,
  output logic            DSP_CE,
  output logic            DSP_RST,
  input  logic [P_W-1:0]  DSP_P,
  output logic            R_VALID,
  input  logic            R_READY,
  output logic [P_W-1:0]  R_DATA
);

  localparam int CNT_W = $clog2(RES_DEPTH + 1);

  logic [1:0]       r_init_cnt;
  logic             r_init_done;
  logic             r_dsp_rst;
  logic             r_dsp_ce;
  logic             r_s_ready;
  logic [OP_W-1:0]  r_dsp_a;
  logic [OP_W-1:0]  r_dsp_b;
  logic [7:0]       r_opmode;
  logic             r_in_vec;
  tag_t             r_tag [0:LAT];  // r_tag[k] describes the operand issued k cycles ago

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_init_next;
  logic [CNT_W-1:0] w_fifo_count;
  logic [OUT_W-1:0] w_lasts;
  logic [OUT_W-1:0] w_outstanding_next;
  logic             w_unused_first;

  assign w_accept       = S_VALID && r_s_ready;
  assign w_push         = r_tag[LAT].vld && r_tag[LAT].last;
  assign w_pop          = R_VALID && R_READY;
  assign w_init_next    = r_init_done || (r_init_cnt == 2'(INIT_CYC - 1));
  assign w_unused_first = r_tag[LAT].first;

  // Hold the slice in reset for INIT_CYC cycles after release, then enable it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_init_cnt  <= 2'd0;
      r_init_done <= 1'b0;
      r_dsp_rst   <= 1'b1;
      r_dsp_ce    <= 1'b0;
    end else if (r_init_cnt != 2'(INIT_CYC)) begin
      r_init_cnt <= r_init_cnt + 2'd1;
      if (r_init_cnt == 2'(INIT_CYC - 1)) begin
        r_init_done <= 1'b1;
        r_dsp_rst   <= 1'b0;
        r_dsp_ce    <= 1'b1;
      end
    end
  end

  // Results owed next cycle: FIFO contents plus every last beat still in flight.
  always_comb begin
    w_lasts = {OUT_W{1'b0}};
    for (int k = 0; k < LAT; k++) begin
      w_lasts = w_lasts + OUT_W'(r_tag[k].vld & r_tag[k].last);
    end
    w_lasts = w_lasts + OUT_W'(w_accept & S_LAST);
    w_outstanding_next = OUT_W'(w_fifo_count) + OUT_W'(w_push) + w_lasts - OUT_W'(w_pop);
  end

  // Registered ready: only accept when a FIFO slot is guaranteed for the result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s_ready <= 1'b0;
    end else begin
      r_s_ready <= w_init_next && (w_outstanding_next < OUT_W'(RES_DEPTH));
    end
  end

  // Operand issue registers and vector-membership flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dsp_a  <= {OP_W{1'b0}};
      r_dsp_b  <= {OP_W{1'b0}};
      r_in_vec <= 1'b0;
    end else if (w_accept) begin
      r_dsp_a  <= S_A;
      r_dsp_b  <= S_B;
      r_in_vec <= !S_LAST;
    end else begin
      r_dsp_a <= {OP_W{1'b0}};
      r_dsp_b <= {OP_W{1'b0}};
    end
  end

  // Tag shift register following each issued operand through the slice.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k <= LAT; k++) begin
        r_tag[k] <= '{vld: 1'b0, first: 1'b0, last: 1'b0};
      end
    end else begin
      r_tag[0] <= '{vld: w_accept, first: w_accept && !r_in_vec, last: w_accept && S_LAST};
      for (int k = 1; k <= LAT; k++) begin
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // OPMODE lags its operand by OPM_SKEW cycles to meet the slice OPMODE register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_opmode <= OPM_HOLD;
    end else begin
      r_opmode <= opm_from_tag(r_tag[OPM_SKEW-1]);
    end
  end

  dsp_result_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (P_W)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .i_push  (w_push),
    .i_data  (DSP_P),
    .i_pop   (w_pop),
    .o_valid (R_VALID),
    .o_data  (R_DATA),
    .o_count (w_fifo_count)
  );

  assign S_READY    = r_s_ready;
  assign DSP_A      = r_dsp_a;
  assign DSP_B      = r_dsp_b;
  assign DSP_OPMODE = r_opmode;
  assign DSP_CE     = r_dsp_ce;
  assign DSP_RST    = r_dsp_rst;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer with a behavioural DSP48A1 slice
// (A1REG/B1REG/MREG/PREG/OPMODEREG = 1, sync active-high reset).
module tb_dsp_mac_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        S_VALID;
  logic        S_READY;
  logic [17:0] S_A;
  logic [17:0] S_B;
  logic        S_LAST;
  logic [17:0] DSP_A;
  logic [17:0] DSP_B;
  logic [7:0]  DSP_OPMODE;
  logic        DSP_CE;
  logic        DSP_RST;
  logic [47:0] DSP_P;
  logic        R_VALID;
  logic        R_READY;
  logic [47:0] R_DATA;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [47:0] sb_q[$];
  logic [47:0] mon_exp;

  always #5 CLK = ~CLK;

  dsp_mac_sequencer dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .S_VALID    (S_VALID),
    .S_READY    (S_READY),
    .S_A        (S_A),
    .S_B        (S_B),
    .S_LAST     (S_LAST),
    .DSP_A      (DSP_A),
    .DSP_B      (DSP_B),
    .DSP_OPMODE (DSP_OPMODE),
    .DSP_CE     (DSP_CE),
    .DSP_RST    (DSP_RST),
    .DSP_P      (DSP_P),
    .R_VALID    (R_VALID),
    .R_READY    (R_READY),
    .R_DATA     (R_DATA)
  );

  // Behavioural slice: A1/B1 -> M -> P, OPMODE registered alongside M.
  logic [17:0] m_a1, m_b1;
  logic [35:0] m_m;
  logic [7:0]  m_opm;
  logic [47:0] m_p;
  logic [47:0] m_x, m_z;
  logic        tb_unused_opm;
  assign tb_unused_opm = |m_opm[6:4];
  assign DSP_P = m_p;

  always_comb begin
    case (m_opm[1:0])
      2'd1:    m_x = {12'd0, m_m};
      default: m_x = 48'd0;
    endcase
    case (m_opm[3:2])
      2'd2:    m_z = m_p;
      default: m_z = 48'd0;
    endcase
  end

  always @(posedge CLK) begin
    if (DSP_RST) begin
      m_a1 <= 18'd0; m_b1 <= 18'd0; m_m <= 36'd0; m_opm <= 8'd0; m_p <= 48'd0;
    end else if (DSP_CE) begin
      m_a1  <= DSP_A;
      m_b1  <= DSP_B;
      m_m   <= m_a1 * m_b1;
      m_opm <= DSP_OPMODE;
      m_p   <= m_opm[7] ? (m_z - m_x) : (m_z + m_x);
    end
  end

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every consumed result is compared with the queue head.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && R_VALID === 1'b1 && R_READY === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got %0h expected none", R_DATA);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("result", R_DATA, mon_exp);
      end
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
    int waited = 0;
    S_VALID = 1'b1; S_A = a; S_B = b; S_LAST = last;
    forever begin
      @(negedge CLK);
      if (S_READY === 1'b1) break;
      waited++;
      if (waited > 200) begin
        n_checks++;
        $display("FAIL send_timeout: got S_READY=%0b expected 1", S_READY);
        break;
      end
    end
    @(posedge CLK);
    #1;
    S_VALID = 1'b0; S_LAST = 1'b0; S_A = 18'd0; S_B = 18'd0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (sb_q.size() != 0 && waited < 500) begin
      @(posedge CLK);
      waited++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    #1;
  endtask

  task automatic wait_ready();
    int waited = 0;
    while (S_READY !== 1'b1 && waited < 50) begin
      @(posedge CLK);
      #1;
      waited++;
    end
    if (S_READY !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_timeout: got %0b expected 1", S_READY);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; S_VALID = 1'b0; S_A = 18'd0; S_B = 18'd0; S_LAST = 1'b0; R_READY = 1'b1;
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    chk("rst_s_ready", {47'd0, S_READY}, 48'd0);
    chk("rst_dsp_a", {30'd0, DSP_A}, 48'd0);
    chk("rst_opmode", {40'd0, DSP_OPMODE}, 48'h08);
    chk("rst_dsp_ce", {47'd0, DSP_CE}, 48'd0);
    chk("rst_dsp_rst", {47'd0, DSP_RST}, 48'd1);
    chk("rst_r_valid", {47'd0, R_VALID}, 48'd0);
    chk("rst_r_data", R_DATA, 48'd0);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("init1_dsp_rst", {47'd0, DSP_RST}, 48'd1);
    chk("init1_s_ready", {47'd0, S_READY}, 48'd0);
    @(posedge CLK); #1;
    chk("init2_dsp_rst", {47'd0, DSP_RST}, 48'd0);
    chk("init2_dsp_ce", {47'd0, DSP_CE}, 48'd1);
    chk("init2_s_ready", {47'd0, S_READY}, 48'd1);

    // 1: three-beat vector, 12+30+56
    sb_q.push_back(48'd98);
    send_beat(18'd3, 18'd4, 1'b0);
    chk("issue_dsp_a", {30'd0, DSP_A}, 48'd3);
    send_beat(18'd5, 18'd6, 1'b0);
    send_beat(18'd7, 18'd8, 1'b1);

    // 2: single full-scale beat
    sb_q.push_back(48'h000F_FFF8_0001);
    send_beat(18'h3FFFF, 18'h3FFFF, 1'b1);
    wait_drain();

    // 3: gap inside a vector, 4+6
    sb_q.push_back(48'd10);
    send_beat(18'd2, 18'd2, 1'b0);
    @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    chk("gap_opm_first", {40'd0, DSP_OPMODE}, 48'h01);
    @(posedge CLK); @(negedge CLK);
    chk("gap_opm_hold", {40'd0, DSP_OPMODE}, 48'h08);
    @(posedge CLK); #1;
    send_beat(18'd2, 18'd3, 1'b1);
    wait_drain();

    // 4: back-pressure with a full result FIFO
    R_READY = 1'b0;
    sb_q.push_back(48'd1);
    send_beat(18'd1, 18'd1, 1'b1);
    sb_q.push_back(48'd4);
    send_beat(18'd2, 18'd2, 1'b1);
    repeat (8) @(posedge CLK);
    @(negedge CLK);
    chk("full_s_ready", {47'd0, S_READY}, 48'd0);
    sb_q.push_back(48'd9);
    fork
      send_beat(18'd3, 18'd3, 1'b1);
      begin
        repeat (4) @(posedge CLK);
        #1 R_READY = 1'b1;
      end
    join
    wait_drain();

    // 5: 2^16 full-scale beats, sum wraps modulo 2^48
    sb_q.push_back(48'hFFF8_0001_0000);
    for (int i = 0; i < 65536; i++) begin
      send_beat(18'h3FFFF, 18'h3FFFF, (i == 65535));
    end
    wait_drain();

    // 6: reset mid-vector, then a fresh one-beat vector
    send_beat(18'd5, 18'd5, 1'b0);
    send_beat(18'd6, 18'd6, 1'b0);
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    wait_ready();
    chk("post_rst_r_valid", {47'd0, R_VALID}, 48'd0);
    sb_q.push_back(48'd1);
    send_beat(18'd1, 18'd1, 1'b1);
    wait_drain();

    repeat (10) @(posedge CLK);
    #1;
    chk("no_extra_result", {47'd0, R_VALID}, 48'd0);
    chk("queue_empty", 48'(sb_q.size()), 48'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
